// File: rtl/addsub_acc_pipe_if.sv
// addsub_acc_pipe_if: operand/result stream bundle for addsub_acc_pipe
//   master: operand source and result consumer (drives beats, out_ready, acc_clr)
//   slave : the pipeline (drives in_ready, out_valid, result, ovf, acc_value)
interface addsub_acc_pipe_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             ovf;
  logic [WIDTH:0]   acc_value;
  modport master (
    output in_valid, op, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, result, ovf, acc_value
  );
  modport slave (
    input  in_valid, op, a, b, acc_clr, out_ready,
    output in_ready, out_valid, result, ovf, acc_value
  );
endinterface

// File: rtl/addsub_acc_pipe.sv
// addsub_acc_pipe: 2-stage add/sub/accumulate pipeline with valid/ready on both sides
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : addsub_acc_pipe_if.slave (operand beat in, result beat out, acc_clr, acc_value)
module addsub_acc_pipe #(
  parameter int WIDTH = 4,
  parameter bit SAT   = 1'b0
) (
  input logic clk,
  input logic rst,
  addsub_acc_pipe_if.slave bus
);
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_LOAD = 2'b11} op_e;
  logic             en;
  logic             commit;
  logic             s1_valid_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             out_valid_q;
  logic [WIDTH:0]   result_q;
  logic [WIDTH:0]   result_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH:0]   a_x;
  logic [WIDTH:0]   b_x;
  logic [WIDTH:0]   acc_base;
  logic [WIDTH+1:0] acc_sum;
  logic [WIDTH:0]   acc_new;
  // Whole pipe advances together; the output register is the only place a beat can wait.
  assign en            = !out_valid_q || bus.out_ready;
  assign commit        = en && s1_valid_q;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.acc_value = acc_q;
  always_comb begin
    a_x      = {1'b0, a_q};
    b_x      = {1'b0, b_q};
    // A clear coinciding with a committing ACC makes that beat start from zero.
    acc_base = bus.acc_clr ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + {2'b00, a_q};
    acc_new  = (SAT && acc_sum[WIDTH+1]) ? '1 : acc_sum[WIDTH:0];
    result_d = op_q == OP_ADD ? a_x + b_x :
               op_q == OP_SUB ? a_x - b_x :
               op_q == OP_ACC ? acc_new : a_x;
    ovf_d    = op_q == OP_SUB ? (a_q < b_q) : (op_q == OP_ACC) && acc_sum[WIDTH+1];
    // ACC and LOAD both write their result into acc; LOAD thereby overrides acc_clr.
    acc_d    = (commit && (op_q == OP_ACC || op_q == OP_LOAD)) ? result_d :
               bus.acc_clr ? '0 : acc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (en) begin
        s1_valid_q  <= bus.in_valid;
        op_q        <= op_e'(bus.op);
        a_q         <= bus.a;
        b_q         <= bus.b;
        out_valid_q <= s1_valid_q;
      end
      if (commit) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
      end
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_addsub_acc_pipe.sv
// tb_addsub_acc_pipe: scoreboard bench driving a wrapping and a saturating instance in lockstep
module tb_addsub_acc_pipe;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;
  typedef struct packed {logic [4:0] r; logic o;} exp_t;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       acc_clr;
  logic       out_ready;
  exp_t       q0[$];
  exp_t       q1[$];
  int         tests = 0;
  int         failed = 0;
  addsub_acc_pipe_if #(.WIDTH(4)) i0 ();
  addsub_acc_pipe_if #(.WIDTH(4)) i1 ();
  assign i0.in_valid  = in_valid;
  assign i0.op        = op;
  assign i0.a         = a;
  assign i0.b         = b;
  assign i0.acc_clr   = acc_clr;
  assign i0.out_ready = out_ready;
  assign i1.in_valid  = in_valid;
  assign i1.op        = op;
  assign i1.a         = a;
  assign i1.b         = b;
  assign i1.acc_clr   = acc_clr;
  assign i1.out_ready = out_ready;
  addsub_acc_pipe #(.WIDTH(4), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  addsub_acc_pipe #(.WIDTH(4), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic send(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                      input logic [4:0] r0, input logic v0, input logic [4:0] r1, input logic v1);
    int n = 0;
    in_valid = 1'b1;
    op = o;
    a = av;
    b = bv;
    @(negedge clk);
    while (!i0.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!i0.in_ready) begin
      tests++;
      failed++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for op %0d a %0d", o, av);
    end
    @(posedge clk);
    q0.push_back({r0, v0});
    q1.push_back({r1, v1});
    #1 in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (i0.out_valid && out_ready) begin
        if (q0.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected0: result %0d with nothing outstanding", i0.result);
        end else begin
          e = q0.pop_front();
          chk("result0", i0.result, e.r);
          chk("ovf0", i0.ovf, e.o);
        end
      end
      if (i1.out_valid && out_ready) begin
        if (q1.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected1: result %0d with nothing outstanding", i1.result);
        end else begin
          e = q1.pop_front();
          chk("result1", i1.result, e.r);
          chk("ovf1", i1.ovf, e.o);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = ADD;
    a = '0;
    b = '0;
    acc_clr = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid0", i0.out_valid, 0);
    chk("rst_out_valid1", i1.out_valid, 0);
    chk("rst_result0", i0.result, 0);
    chk("rst_acc0", i0.acc_value, 0);
    chk("rst_acc1", i1.acc_value, 0);
    chk("rst_ovf0", i0.ovf, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", i0.in_ready, 1);
    send(ADD, 15, 15, 30, 0, 30, 0);
    chk("latency_not_early", i0.out_valid, 0);
    @(posedge clk);
    #1;
    chk("latency_two_edges", i0.out_valid, 1);
    send(SUB, 3, 5, 30, 1, 30, 1);
    send(SUB, 9, 4, 5, 0, 5, 0);
    send(LOAD, 0, 0, 0, 0, 0, 0);
    send(ACC, 15, 0, 15, 0, 15, 0);
    send(ACC, 15, 0, 30, 0, 30, 0);
    send(ACC, 15, 0, 13, 1, 31, 1);
    idle(3);
    chk("acc_wrap", i0.acc_value, 13);
    chk("acc_sat", i1.acc_value, 31);
    send(ADD, 1, 2, 3, 0, 3, 0);
    send(ADD, 7, 8, 15, 0, 15, 0);
    out_ready = 1'b0;
    fork
      begin
        send(ADD, 10, 11, 21, 0, 21, 0);
        send(ADD, 15, 1, 16, 0, 16, 0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", i0.in_ready, 0);
          chk("stall_out_valid", i0.out_valid, 1);
          chk("stall_result", i0.result, 3);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);
    chk("stall_acc_kept", i0.acc_value, 13);
    send(LOAD, 15, 0, 15, 0, 15, 0);
    send(ACC, 5, 0, 20, 0, 20, 0);
    send(ACC, 7, 0, 7, 0, 7, 0);
    acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    chk("clr_with_acc0", i0.acc_value, 7);
    chk("clr_with_acc1", i1.acc_value, 7);
    idle(3);
    send(ADD, 1, 1, 2, 0, 2, 0);
    out_ready = 1'b0;
    @(posedge clk);
    #1 acc_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_in_stall_acc0", i0.acc_value, 0);
    chk("clr_in_stall_acc1", i1.acc_value, 0);
    chk("clr_in_stall_valid", i0.out_valid, 1);
    chk("clr_in_stall_result", i0.result, 2);
    acc_clr = 1'b0;
    out_ready = 1'b1;
    idle(3);
    send(LOAD, 9, 0, 9, 0, 9, 0);
    idle(3);
    chk("load_acc", i0.acc_value, 9);
    send(ADD, 2, 3, 5, 0, 5, 0);
    send(ADD, 4, 4, 8, 0, 8, 0);
    #2 rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("async_out_valid0", i0.out_valid, 0);
    chk("async_out_valid1", i1.out_valid, 0);
    chk("async_result0", i0.result, 0);
    chk("async_acc0", i0.acc_value, 0);
    chk("async_acc1", i1.acc_value, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    idle(1);
    chk("in_ready_after_async", i0.in_ready, 1);
    idle(5);
    chk("no_stale_valid", i0.out_valid, 0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
